// File: rtl/multi_channel_creditor_if.sv
// Valid/ready stream carrying NUM_ELEMENTS lanes of data_t with per-lane keep and a last flag.
interface ndata_i #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 4
);
  data_t [NUM_ELEMENTS-1:0] data;
  logic  [NUM_ELEMENTS-1:0] keep;
  logic                     last;
  logic                     valid;
  logic                     ready;

  modport s (input data, keep, last, valid, output ready);
  modport m (output data, keep, last, valid, input ready);
endinterface

// File: rtl/multi_channel_creditor.sv
// Per-channel credit gate: beats flow in[c] -> out[c] only while channel c has credit.
// One creditor_lane per channel owns the in-flight counter and sticky error.
module creditor_lane #(
  parameter int MAX_IN_TRANSIT = 16,
  parameter int RET_W          = 2,
  parameter int BYPASS_RETURN  = 1,
  parameter int CNT_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] lim,
  input  logic [RET_W-1:0] ret,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             allow,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  // One spare bit so the MSB of cnt - ret is the borrow.
  localparam int W = ((CNT_W > RET_W) ? CNT_W : RET_W) + 1;

  logic [W-1:0] diff, drained, eff;
  logic         under, take;

  always_comb begin
    diff    = W'(cnt) - W'(ret);
    under   = diff[W-1];
    drained = under ? '0 : diff;
    eff     = (BYPASS_RETURN != 0) ? drained : W'(cnt);
  end

  // rst_n gating keeps both handshake outputs low for the whole reset window.
  assign allow = rst_n & (eff < W'(lim));
  assign take  = in_valid & out_ready & allow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= CNT_W'(drained + W'(take));
      if (under) err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CNT_W'(MAX_IN_TRANSIT));
`endif
endmodule

module multi_channel_creditor #(
  parameter int  NUM_CHANNELS   = 4,
  parameter int  MAX_IN_TRANSIT = 16,
  parameter int  RET_W          = 2,
  parameter int  BYPASS_RETURN  = 1,
  localparam int CNT_W          = $clog2(MAX_IN_TRANSIT + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ndata_i.s                             in  [NUM_CHANNELS],
  ndata_i.m                             out [NUM_CHANNELS],
  input  logic [NUM_CHANNELS*RET_W-1:0] credit_return,
  input  logic [CNT_W-1:0]              cfg_limit,
  output logic [NUM_CHANNELS*CNT_W-1:0] in_flight,
  output logic [NUM_CHANNELS-1:0]       credit_err
);
  logic [CNT_W-1:0]        lim;
  logic [NUM_CHANNELS-1:0] allow;

  assign lim = (cfg_limit > CNT_W'(MAX_IN_TRANSIT)) ? CNT_W'(MAX_IN_TRANSIT) : cfg_limit;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    creditor_lane #(
      .MAX_IN_TRANSIT(MAX_IN_TRANSIT),
      .RET_W         (RET_W),
      .BYPASS_RETURN (BYPASS_RETURN),
      .CNT_W         (CNT_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .lim      (lim),
      .ret      (credit_return[g*RET_W +: RET_W]),
      .in_valid (in[g].valid),
      .out_ready(out[g].ready),
      .allow    (allow[g]),
      .cnt      (in_flight[g*CNT_W +: CNT_W]),
      .err      (credit_err[g])
    );

    // allow never depends on out.ready, so valid has no path from ready.
    assign out[g].data  = in[g].data;
    assign out[g].keep  = in[g].keep;
    assign out[g].last  = in[g].last;
    assign out[g].valid = in[g].valid & allow[g];
    assign in[g].ready  = out[g].ready & allow[g];
  end

`ifndef SYNTHESIS
  a_ret_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(credit_return));
  a_lim_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(cfg_limit));
`endif
endmodule

// File: tb/tb_multi_channel_creditor.sv
// Bench for multi_channel_creditor: a bypass and a non-bypass instance share stimulus
// and are scored against a plain-integer credit model.
module tb_multi_channel_creditor;
  localparam int NC  = 4;
  localparam int MAX = 4;
  localparam int RW  = 2;
  localparam int CW  = 3;
  localparam int NE  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0][NE-1:0][7:0] din, doa;
  logic [NC-1:0][NE-1:0]      kin, koa;
  logic [NC-1:0]              lin, loa, vin, rdy, ova, ira, ovb, irb;
  logic [NC-1:0][RW-1:0]      retv;
  logic [CW-1:0]              cfg_limit;
  logic [NC-1:0][CW-1:0]      ifl_a, ifl_b;
  logic [NC-1:0]              err_a, err_b;

  ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(NE)) in_a [NC] ();
  ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(NE)) out_a[NC] ();
  ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(NE)) in_b [NC] ();
  ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(NE)) out_b[NC] ();

  for (genvar g = 0; g < NC; g++) begin : g_br
    assign in_a[g].data   = din[g];
    assign in_a[g].keep   = kin[g];
    assign in_a[g].last   = lin[g];
    assign in_a[g].valid  = vin[g];
    assign out_a[g].ready = rdy[g];
    assign in_b[g].data   = din[g];
    assign in_b[g].keep   = kin[g];
    assign in_b[g].last   = lin[g];
    assign in_b[g].valid  = vin[g];
    assign out_b[g].ready = rdy[g];
    assign ova[g] = out_a[g].valid;
    assign ira[g] = in_a[g].ready;
    assign doa[g] = out_a[g].data;
    assign koa[g] = out_a[g].keep;
    assign loa[g] = out_a[g].last;
    assign ovb[g] = out_b[g].valid;
    assign irb[g] = in_b[g].ready;
  end

  multi_channel_creditor #(.NUM_CHANNELS(NC), .MAX_IN_TRANSIT(MAX), .RET_W(RW), .BYPASS_RETURN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a), .credit_return(retv),
    .cfg_limit(cfg_limit), .in_flight(ifl_a), .credit_err(err_a));

  multi_channel_creditor #(.NUM_CHANNELS(NC), .MAX_IN_TRANSIT(MAX), .RET_W(RW), .BYPASS_RETURN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b), .credit_return(retv),
    .cfg_limit(cfg_limit), .in_flight(ifl_b), .credit_err(err_b));

  int checks = 0, failures = 0;
  int mc_a[NC], mc_b[NC];
  bit me_a[NC], me_b[NC];

  // Credits available this cycle, straight from the gate rules.
  function automatic bit allow_m(int cnt, int r, bit byp);
    int lim, eff;
    lim = (int'(cfg_limit) > MAX) ? MAX : int'(cfg_limit);
    eff = byp ? ((cnt > r) ? cnt - r : 0) : cnt;
    return rst_n && (eff < lim);
  endfunction

  function automatic void zero_model();
    for (int c = 0; c < NC; c++) begin
      mc_a[c] = 0; mc_b[c] = 0; me_a[c] = 0; me_b[c] = 0;
    end
  endfunction

  // Apply one clock of the current inputs to the model, then step past the edge.
  task automatic adv();
    int r;
    bit ta, tb;
    if (rst_n) begin
      for (int c = 0; c < NC; c++) begin
        r  = int'(retv[c]);
        ta = vin[c] && rdy[c] && allow_m(mc_a[c], r, 1'b1);
        tb = vin[c] && rdy[c] && allow_m(mc_b[c], r, 1'b0);
        if (r > mc_a[c]) me_a[c] = 1;
        if (r > mc_b[c]) me_b[c] = 1;
        mc_a[c] = ((mc_a[c] > r) ? mc_a[c] - r : 0) + int'(ta);
        mc_b[c] = ((mc_b[c] > r) ? mc_b[c] - r : 0) + int'(tb);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    vin = '0; rdy = '0; retv = '0; din = '0; kin = '0; lin = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; zero_model(); idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; zero_model(); idle_inputs();
    vin = '1; rdy = '1; cfg_limit = 3'd4;
    #1;
    for (int c = 0; c < NC; c++) begin
      checks++;
      if ({ova[c], ira[c], ovb[c], irb[c]} !== 4'b0) begin
        failures++; $display("FAIL reset_hs c=%0d got %b exp 0000", c, {ova[c], ira[c], ovb[c], irb[c]});
      end
      checks++;
      if (ifl_a[c] !== 3'd0 || ifl_b[c] !== 3'd0) begin
        failures++; $display("FAIL reset_inflight c=%0d got %0d/%0d exp 0", c, ifl_a[c], ifl_b[c]);
      end
    end
    checks++;
    if (err_a !== '0 || err_b !== '0) begin
      failures++; $display("FAIL reset_err got %b/%b exp 0", err_a, err_b);
    end
    vin = '0; rdy = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    int beats_a = 0, beats_b = 0;
    vin[0] = 1'b1; rdy[0] = 1'b1;
    repeat (6) begin
      #1;
      checks++;
      if (ova[0] !== allow_m(mc_a[0], 0, 1'b1)) begin
        failures++; $display("FAIL fill_valid got %b exp %b", ova[0], allow_m(mc_a[0], 0, 1'b1));
      end
      beats_a += int'(ova[0] & ira[0]);
      beats_b += int'(ovb[0] & irb[0]);
      adv();
    end
    #1;
    checks++;
    if (beats_a != 4 || beats_b != 4) begin
      failures++; $display("FAIL fill_beats got %0d/%0d exp 4", beats_a, beats_b);
    end
    checks++;
    if (ifl_a[0] !== 3'd4 || ifl_b[0] !== 3'd4) begin
      failures++; $display("FAIL fill_inflight got %0d/%0d exp 4", ifl_a[0], ifl_b[0]);
    end
    checks++;
    if ({ova[0], ira[0], ovb[0], irb[0]} !== 4'b0) begin
      failures++; $display("FAIL fill_blocked got %b exp 0000", {ova[0], ira[0], ovb[0], irb[0]});
    end
  endtask

  task automatic test_bypass();
    retv[0] = 2'd2; #1;
    checks++;
    if (ova[0] !== 1'b1 || ira[0] !== 1'b1) begin
      failures++; $display("FAIL byp1_same_cycle got v=%b r=%b exp 1/1", ova[0], ira[0]);
    end
    checks++;
    if (ovb[0] !== 1'b0) begin
      failures++; $display("FAIL byp0_same_cycle got %b exp 0", ovb[0]);
    end
    adv();
    retv[0] = 2'd0; #1;
    checks++;
    if (ifl_a[0] !== 3'd3 || ifl_b[0] !== 3'd2) begin
      failures++; $display("FAIL byp_inflight got %0d/%0d exp 3/2", ifl_a[0], ifl_b[0]);
    end
    checks++;
    if (ovb[0] !== 1'b1) begin
      failures++; $display("FAIL byp0_next_cycle got %b exp 1", ovb[0]);
    end
    adv();
  endtask

  task automatic test_cancel();
    do_reset();
    vin[0] = 1'b1; rdy[0] = 1'b1;
    adv();
    retv[0] = 2'd1; #1;
    checks++;
    if (ova[0] !== 1'b1 || ovb[0] !== 1'b1) begin
      failures++; $display("FAIL cancel_valid got %b/%b exp 1/1", ova[0], ovb[0]);
    end
    adv();
    retv[0] = 2'd0; vin = '0; #1;
    checks++;
    if (ifl_a[0] !== 3'd1 || ifl_b[0] !== 3'd1 || err_a !== '0 || err_b !== '0) begin
      failures++; $display("FAIL cancel_state got %0d/%0d err %b/%b exp 1/1 err 0", ifl_a[0], ifl_b[0], err_a, err_b);
    end
  endtask

  task automatic test_overflow();
    retv[0] = 2'd3;
    adv();
    retv[0] = 2'd0; #1;
    checks++;
    if (ifl_a[0] !== 3'd0 || ifl_b[0] !== 3'd0) begin
      failures++; $display("FAIL ovf_inflight got %0d/%0d exp 0", ifl_a[0], ifl_b[0]);
    end
    checks++;
    if (err_a !== 4'b0001 || err_b !== 4'b0001) begin
      failures++; $display("FAIL ovf_err got %b/%b exp 0001", err_a, err_b);
    end
    vin[0] = 1'b1;
    repeat (5) adv();
    checks++;
    if (err_a !== 4'b0001 || err_b !== 4'b0001) begin
      failures++; $display("FAIL ovf_sticky got %b/%b exp 0001", err_a, err_b);
    end
    rst_n = 1'b0; zero_model(); #1;
    checks++;
    if (err_a !== '0 || err_b !== '0) begin
      failures++; $display("FAIL ovf_reset_clear got %b/%b exp 0", err_a, err_b);
    end
    do_reset();
  endtask

  task automatic test_limit();
    cfg_limit = 3'd4;
    vin[1] = 1'b1; rdy[1] = 1'b1;
    repeat (3) adv();
    cfg_limit = 3'd2; #1;
    checks++;
    if ({ova[1], ira[1], ovb[1], irb[1]} !== 4'b0) begin
      failures++; $display("FAIL lim_lowered_block got %b exp 0000", {ova[1], ira[1], ovb[1], irb[1]});
    end
    vin[1] = 1'b0; retv[1] = 2'd1;
    adv(); adv();
    retv[1] = 2'd0; #1;
    checks++;
    if (ifl_a[1] !== 3'd1 || ifl_b[1] !== 3'd1 || err_a !== '0 || err_b !== '0) begin
      failures++; $display("FAIL lim_drain got %0d/%0d err %b/%b exp 1/1 err 0", ifl_a[1], ifl_b[1], err_a, err_b);
    end
    vin[1] = 1'b1; #1;
    checks++;
    if (ova[1] !== 1'b1 || ovb[1] !== 1'b1) begin
      failures++; $display("FAIL lim_resume got %b/%b exp 1/1", ova[1], ovb[1]);
    end
    adv();
    cfg_limit = 3'd0; vin = '1; rdy = '1; retv[1] = 2'd2; #1;
    checks++;
    if (ova !== '0 || ira !== '0 || ovb !== '0 || irb !== '0) begin
      failures++; $display("FAIL lim_zero_block got %b %b %b %b exp all 0", ova, ira, ovb, irb);
    end
    adv();
    retv = '0; #1;
    checks++;
    if (ifl_a[1] !== 3'd0 || ifl_b[1] !== 3'd0 || err_a !== '0 || err_b !== '0) begin
      failures++; $display("FAIL lim_zero_drain got %0d/%0d err %b/%b exp 0/0 err 0", ifl_a[1], ifl_b[1], err_a, err_b);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    cfg_limit = 3'd7;
    vin[2] = 1'b1; rdy[2] = 1'b1;
    repeat (6) adv();
    checks++;
    if (ifl_a[2] !== 3'd4 || ifl_b[2] !== 3'd4 || ova[2] !== 1'b0) begin
      failures++; $display("FAIL clamp got %0d/%0d v=%b exp 4/4 v=0", ifl_a[2], ifl_b[2], ova[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 50 == 0) cfg_limit = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      if (cyc == 200) begin rst_n = 1'b0; zero_model(); end
      if (cyc == 203) rst_n = 1'b1;
      for (int c = 0; c < NC; c++) begin
        vin[c] = 1'($urandom_range(0, 3) != 0);
        rdy[c] = 1'($urandom_range(0, 3) != 0);
        din[c] = 16'($urandom);
        kin[c] = 2'($urandom);
        lin[c] = 1'($urandom);
        if ($urandom_range(0, 39) == 0) retv[c] = 2'($urandom_range(0, 3));
        else if (mc_a[c] > 0 && mc_b[c] > 0 && $urandom_range(0, 2) == 0)
          retv[c] = 2'($urandom_range(1, (mc_b[c] < 3) ? mc_b[c] : 3));
        else retv[c] = 2'd0;
      end
      #1;
      for (int c = 0; c < NC; c++) begin
        checks++;
        if (ova[c] !== (vin[c] & allow_m(mc_a[c], int'(retv[c]), 1'b1)) ||
            ira[c] !== (rdy[c] & allow_m(mc_a[c], int'(retv[c]), 1'b1))) begin
          failures++; $display("FAIL rnd_hs_a cyc=%0d c=%0d got v=%b r=%b", cyc, c, ova[c], ira[c]);
        end
        checks++;
        if (ovb[c] !== (vin[c] & allow_m(mc_b[c], int'(retv[c]), 1'b0)) ||
            irb[c] !== (rdy[c] & allow_m(mc_b[c], int'(retv[c]), 1'b0))) begin
          failures++; $display("FAIL rnd_hs_b cyc=%0d c=%0d got v=%b r=%b", cyc, c, ovb[c], irb[c]);
        end
        checks++;
        if (doa[c] !== din[c] || koa[c] !== kin[c] || loa[c] !== lin[c]) begin
          failures++; $display("FAIL rnd_data cyc=%0d c=%0d got %h exp %h", cyc, c, doa[c], din[c]);
        end
        checks++;
        if (int'(ifl_a[c]) != mc_a[c] || int'(ifl_b[c]) != mc_b[c]) begin
          failures++; $display("FAIL rnd_inflight cyc=%0d c=%0d got %0d/%0d exp %0d/%0d", cyc, c, ifl_a[c], ifl_b[c], mc_a[c], mc_b[c]);
        end
        checks++;
        if (err_a[c] !== me_a[c] || err_b[c] !== me_b[c]) begin
          failures++; $display("FAIL rnd_err cyc=%0d c=%0d got %b/%b exp %b/%b", cyc, c, err_a[c], err_b[c], me_a[c], me_b[c]);
        end
      end
      adv();
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_limit = 3'd4; idle_inputs(); zero_model();
    test_reset();
    test_fill();
    test_bypass();
    test_cancel();
    test_overflow();
    test_limit();
    test_clamp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
